// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the dual-channel fp16 3x3 conv engine.
// Loads 9 weight words, streams ifmap tiles, forwards engine results.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      run control (abort has priority)
//   busy, done        run status; busy gates host buffer writes
//   buf_rd_*          buffer read port (data valid 1 cycle after en)
//   eng_wgt_valid     weight word presented on eng_data/eng_idx
//   eng_ifm_valid     ifmap word presented on eng_data/eng_idx
//   eng_tile_go       pulse: tile loaded, start compute
//   eng_res_*         engine result strobe and fp16 value
//   dout_valid        pulse per forwarded result on ofmap_out
//   res_err           sticky: result strobe outside result window
module conv_seq_ctrl #(
   parameter int                TILE_NUM     = 30,
   parameter int                TILE_WORDS   = 16,
   parameter int                WGT_WORDS    = 9,
   parameter int                RES_PER_TILE = 4,
   parameter int                ADDR_W       = 12,
   parameter logic [ADDR_W-1:0] IFM_BASE     = 12'd1,
   parameter logic [ADDR_W-1:0] WGT_BASE     = 12'd4079
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              buf_rd_en,
   output logic [ADDR_W-1:0] buf_rd_addr,
   input  logic [31:0]       buf_rd_data,
   output logic              eng_wgt_valid,
   output logic              eng_ifm_valid,
   output logic [31:0]       eng_data,
   output logic [3:0]        eng_idx,
   output logic              eng_tile_go,
   input  logic              eng_res_valid,
   input  logic [15:0]       eng_res_data,
   output logic              dout_valid,
   output logic [31:0]       ofmap_out,
   output logic              res_err
);

   localparam int TW = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;
   localparam int RW = $clog2(RES_PER_TILE) + 1;

   localparam logic [3:0]        WGT_LAST  = 4'(WGT_WORDS - 1);
   localparam logic [3:0]        WRD_LAST  = 4'(TILE_WORDS - 1);
   localparam logic [TW-1:0]     TILE_LAST = TW'(TILE_NUM - 1);
   localparam logic [RW-1:0]     RES_LAST  = RW'(RES_PER_TILE - 1);
   localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(TILE_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_WGT,
      S_LD_TILE,
      S_FLUSH,
      S_GO,
      S_WAIT_RES,
      S_DONE
   } state_t;

   state_t state;
   state_t nxt;

   logic [TW-1:0] tile_cnt;
   logic [3:0]    word_cnt;
   logic [RW-1:0] res_cnt;

   // Delayed copy of the read strobe, phase and index; tags the
   // data returned by the buffer one cycle after each read.
   logic          pipe_vld;
   logic          pipe_wgt;
   logic [3:0]    pipe_idx;

   logic          idle_like;
   logic          go_ok;
   logic          in_res;
   logic          res_last;
   logic          tile_last;
   logic [ADDR_W-1:0] ifm_addr;
   logic [ADDR_W-1:0] wgt_addr;

   assign idle_like = (state == S_IDLE) || (state == S_DONE);
   assign go_ok     = idle_like && start && !abort;
   assign in_res    = (state == S_WAIT_RES);
   assign res_last  = eng_res_valid && (res_cnt == RES_LAST);
   assign tile_last = (tile_cnt == TILE_LAST);

   assign wgt_addr = WGT_BASE + ADDR_W'(word_cnt);
   assign ifm_addr = IFM_BASE
                   + ADDR_W'(tile_cnt) * STRIDE
                   + ADDR_W'(word_cnt);

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= nxt;
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      if (abort) begin
         nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start)
                  nxt = S_LD_WGT;
            end
            S_LD_WGT: begin
               if (word_cnt == WGT_LAST)
                  nxt = S_LD_TILE;
            end
            S_LD_TILE: begin
               if (word_cnt == WRD_LAST)
                  nxt = S_FLUSH;
            end
            S_FLUSH: nxt = S_GO;
            S_GO:    nxt = S_WAIT_RES;
            S_WAIT_RES: begin
               if (res_last)
                  nxt = tile_last ? S_DONE : S_LD_TILE;
            end
            default: nxt = S_IDLE;
         endcase
      end
   end

   // Output decode
   always_comb begin
      busy        = 1'b1;
      done        = 1'b0;
      buf_rd_en   = 1'b0;
      buf_rd_addr = '0;
      eng_tile_go = 1'b0;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         S_LD_WGT: begin
            buf_rd_en   = 1'b1;
            buf_rd_addr = wgt_addr;
         end
         S_LD_TILE: begin
            buf_rd_en   = 1'b1;
            buf_rd_addr = ifm_addr;
         end
         S_GO: begin
            eng_tile_go = 1'b1;
         end
         S_FLUSH, S_WAIT_RES: begin
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Run counters
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         tile_cnt <= '0;
         word_cnt <= '0;
         res_cnt  <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  tile_cnt <= '0;
                  word_cnt <= '0;
                  res_cnt  <= '0;
               end
            end
            S_LD_WGT: begin
               if (word_cnt == WGT_LAST)
                  word_cnt <= '0;
               else
                  word_cnt <= word_cnt + 4'd1;
            end
            S_LD_TILE: begin
               if (word_cnt == WRD_LAST)
                  word_cnt <= '0;
               else
                  word_cnt <= word_cnt + 4'd1;
            end
            S_WAIT_RES: begin
               if (res_last) begin
                  res_cnt <= '0;
                  if (!tile_last)
                     tile_cnt <= tile_cnt + 1'b1;
               end else if (eng_res_valid) begin
                  res_cnt <= res_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Read-data tagging; abort kills the tag of an in-flight read.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         pipe_vld <= 1'b0;
         pipe_wgt <= 1'b0;
         pipe_idx <= '0;
      end else begin
         pipe_vld <= buf_rd_en;
         pipe_wgt <= (state == S_LD_WGT);
         pipe_idx <= word_cnt;
      end
   end

   assign eng_data      = buf_rd_data;
   assign eng_wgt_valid = pipe_vld && pipe_wgt;
   assign eng_ifm_valid = pipe_vld && !pipe_wgt;
   assign eng_idx       = pipe_vld ? pipe_idx : 4'd0;

   // Result forwarding and stray-result flag. A stray strobe on the
   // same cycle as an accepted start still sets the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid <= 1'b0;
         ofmap_out  <= '0;
         res_err    <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (in_res && eng_res_valid && !abort) begin
            dout_valid <= 1'b1;
            ofmap_out  <= {16'h0, eng_res_data};
         end
         if (go_ok)
            res_err <= 1'b0;
         if (eng_res_valid && !in_res)
            res_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed bench for conv_seq_ctrl with a buffer
// model, an engine model and immediate-assertion checks.
module tb_conv_seq_ctrl;

   localparam logic [11:0] WGT_BASE = 12'd4079;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        buf_rd_en;
   logic [11:0] buf_rd_addr;
   logic [31:0] buf_rd_data = 32'h0;
   logic        eng_wgt_valid;
   logic        eng_ifm_valid;
   logic [31:0] eng_data;
   logic [3:0]  eng_idx;
   logic        eng_tile_go;
   logic        eng_res_valid;
   logic [15:0] eng_res_data;
   logic        dout_valid;
   logic [31:0] ofmap_out;
   logic        res_err;

   logic        mdl_vld;
   logic [15:0] mdl_dat;
   logic        mdl_en;
   logic        man_vld;
   logic [15:0] man_dat;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign eng_res_valid = mdl_vld | man_vld;
   assign eng_res_data  = man_vld ? man_dat : mdl_dat;

   conv_seq_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .busy          (busy),
      .done          (done),
      .buf_rd_en     (buf_rd_en),
      .buf_rd_addr   (buf_rd_addr),
      .buf_rd_data   (buf_rd_data),
      .eng_wgt_valid (eng_wgt_valid),
      .eng_ifm_valid (eng_ifm_valid),
      .eng_data      (eng_data),
      .eng_idx       (eng_idx),
      .eng_tile_go   (eng_tile_go),
      .eng_res_valid (eng_res_valid),
      .eng_res_data  (eng_res_data),
      .dout_valid    (dout_valid),
      .ofmap_out     (ofmap_out),
      .res_err       (res_err)
   );

   function automatic logic [31:0] pat(input logic [11:0] a);
      return {20'hC0DE5, a};
   endfunction

   // Buffer: data one cycle after the read strobe
   always @(posedge clk)
      if (buf_rd_en)
         buf_rd_data <= pat(buf_rd_addr);

   // Engine: 4 results starting 5 cycles after each go
   initial begin : engine
      int res_n;
      res_n   = 0;
      mdl_vld = 1'b0;
      mdl_dat = 16'h0;
      forever begin
         @(negedge clk);
         if (eng_tile_go && mdl_en) begin
            repeat (5) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
               mdl_vld = 1'b1;
               mdl_dat = 16'h3C00 + 16'(res_n);
               res_n++;
               @(negedge clk);
            end
            mdl_vld = 1'b0;
         end
      end
   end

   // Event counters and stream-order monitor
   int rd_n = 0, wgt_n = 0, ifm_n = 0, go_n = 0;
   int dout_n = 0, bad_n = 0, dbad_n = 0, dout_base = 0;
   logic        chk_dout = 1'b0;
   logic [11:0] exp_ifm = 12'd1;
   logic [11:0] last_addr = 12'd0;
   logic        last_en = 1'b0;

   always @(negedge clk) begin
      if (eng_wgt_valid) begin
         wgt_n++;
         if (!last_en || eng_data !== pat(last_addr) ||
             eng_idx !== 4'(last_addr - WGT_BASE))
            bad_n++;
      end
      if (eng_ifm_valid) begin
         ifm_n++;
         if (!last_en || eng_data !== pat(last_addr) ||
             eng_idx !== 4'(last_addr - 12'd1))
            bad_n++;
      end
      if (eng_wgt_valid && eng_ifm_valid)
         bad_n++;
      if (eng_tile_go)
         go_n++;
      if (dout_valid) begin
         if (chk_dout &&
             ofmap_out !== 32'h3C00 + 32'(dout_n - dout_base))
            dbad_n++;
         dout_n++;
      end
      if (buf_rd_en) begin
         rd_n++;
         if (buf_rd_addr >= WGT_BASE) begin
            exp_ifm = 12'd1;
         end else begin
            if (buf_rd_addr !== exp_ifm)
               bad_n++;
            exp_ifm = buf_rd_addr + 12'd1;
         end
      end
      last_en   = buf_rd_en;
      last_addr = buf_rd_addr;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_rd_en"}, 32'(buf_rd_en), 32'd0);
      chk({tag, "_addr"}, 32'(buf_rd_addr), 32'd0);
      chk({tag, "_wgt_v"}, 32'(eng_wgt_valid), 32'd0);
      chk({tag, "_ifm_v"}, 32'(eng_ifm_valid), 32'd0);
      chk({tag, "_idx"}, 32'(eng_idx), 32'd0);
      chk({tag, "_go"}, 32'(eng_tile_go), 32'd0);
      chk({tag, "_dout_v"}, 32'(dout_valid), 32'd0);
      chk({tag, "_ofmap"}, ofmap_out, 32'd0);
   endtask

   initial begin : main
      int t;
      int s_rd, s_wgt, s_ifm, s_go, s_dout, s_bad;
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      man_vld = 1'b0;
      man_dat = 16'h0;
      mdl_en  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      s_rd = rd_n;

      // Idle after reset
      repeat (20) @(posedge clk);
      #1;
      chk_reset_outs("idle");
      chk("idle_res_err", 32'(res_err), 32'd0);
      chk("idle_reads", 32'(rd_n - s_rd), 32'd0);

      // Stray result in IDLE
      s_dout = dout_n;
      @(negedge clk);
      man_vld = 1'b1;
      man_dat = 16'h1234;
      @(negedge clk);
      man_vld = 1'b0;
      chk("stray_err", 32'(res_err), 32'd1);
      chk("stray_dout_v", 32'(dout_valid), 32'd0);
      @(negedge clk);
      chk("stray_dout_n", 32'(dout_n - s_dout), 32'd0);
      chk("stray_ofmap", ofmap_out, 32'd0);

      // Full run with cycle-exact checks from E0
      s_rd = rd_n; s_wgt = wgt_n; s_ifm = ifm_n;
      s_go = go_n; s_bad = bad_n;
      dout_base = dout_n;
      s_dout    = dout_n;
      chk_dout  = 1'b1;
      pulse_start();
      chk("e0_addr", 32'(buf_rd_addr), 32'd4079);
      chk("e0_rd_en", 32'(buf_rd_en), 32'd1);
      chk("e0_busy", 32'(busy), 32'd1);
      chk("e0_res_err", 32'(res_err), 32'd0);
      chk("e0_wgt_v", 32'(eng_wgt_valid), 32'd0);
      @(posedge clk); #1;
      chk("e1_wgt_v", 32'(eng_wgt_valid), 32'd1);
      chk("e1_idx", 32'(eng_idx), 32'd0);
      chk("e1_addr", 32'(buf_rd_addr), 32'd4080);
      repeat (8) @(posedge clk); #1;
      chk("e9_addr", 32'(buf_rd_addr), 32'd1);
      chk("e9_wgt_v", 32'(eng_wgt_valid), 32'd1);
      chk("e9_idx", 32'(eng_idx), 32'd8);
      chk("e9_ifm_v", 32'(eng_ifm_valid), 32'd0);
      @(posedge clk); #1;
      chk("e10_ifm_v", 32'(eng_ifm_valid), 32'd1);
      chk("e10_wgt_v", 32'(eng_wgt_valid), 32'd0);
      chk("e10_idx", 32'(eng_idx), 32'd0);
      repeat (15) @(posedge clk); #1;
      chk("e25_rd_en", 32'(buf_rd_en), 32'd0);
      chk("e25_ifm_v", 32'(eng_ifm_valid), 32'd1);
      chk("e25_idx", 32'(eng_idx), 32'd15);
      chk("e25_go", 32'(eng_tile_go), 32'd0);
      @(posedge clk); #1;
      chk("e26_go", 32'(eng_tile_go), 32'd1);
      chk("e26_ifm_v", 32'(eng_ifm_valid), 32'd0);
      @(posedge clk); #1;
      chk("e27_go", 32'(eng_tile_go), 32'd0);
      t = 0;
      while (!done && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("run_done", 32'(done), 32'd1);
      chk("run_busy", 32'(busy), 32'd0);
      chk("run_last_dv", 32'(dout_valid), 32'd1);
      chk("run_last_val", ofmap_out, 32'h00003C77);
      @(posedge clk); #1;
      chk("run_dv_drop", 32'(dout_valid), 32'd0);
      chk("run_done_hold", 32'(done), 32'd1);
      chk("run_ofmap_hold", ofmap_out, 32'h00003C77);
      @(negedge clk);
      chk_dout = 1'b0;
      chk("run_wgt_n", 32'(wgt_n - s_wgt), 32'd9);
      chk("run_ifm_n", 32'(ifm_n - s_ifm), 32'd480);
      chk("run_rd_n", 32'(rd_n - s_rd), 32'd489);
      chk("run_go_n", 32'(go_n - s_go), 32'd30);
      chk("run_dout_n", 32'(dout_n - s_dout), 32'd120);
      chk("run_order", 32'(bad_n - s_bad), 32'd0);
      chk("run_values", 32'(dbad_n), 32'd0);
      chk("run_res_err", 32'(res_err), 32'd0);

      // Abort at tile 3 word 7 (address 56)
      s_go = go_n; s_dout = dout_n;
      pulse_start();
      chk("ab_done_clr", 32'(done), 32'd0);
      t = 0;
      while (!(buf_rd_en && buf_rd_addr == 12'd56) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("ab_at", 32'(buf_rd_addr), 32'd56);
      chk("ab_go_n", 32'(go_n - s_go), 32'd3);
      chk("ab_dout_n", 32'(dout_n - s_dout), 32'd12);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_rd_en", 32'(buf_rd_en), 32'd0);
      chk("ab_ifm_v", 32'(eng_ifm_valid), 32'd0);
      chk("ab_done", 32'(done), 32'd0);
      s_rd = rd_n; s_go = go_n; s_dout = dout_n; s_ifm = ifm_n;
      repeat (15) @(posedge clk); #1;
      chk("ab_no_rd", 32'(rd_n - s_rd), 32'd0);
      chk("ab_no_go", 32'(go_n - s_go), 32'd0);
      chk("ab_no_dout", 32'(dout_n - s_dout), 32'd0);
      chk("ab_no_ifm", 32'(ifm_n - s_ifm), 32'd0);
      chk("ab_done2", 32'(done), 32'd0);

      // Rerun; start during LD_TILE is ignored
      s_bad = bad_n;
      pulse_start();
      chk("rr_addr", 32'(buf_rd_addr), 32'd4079);
      repeat (12) @(posedge clk); #1;
      chk("rr_e12_addr", 32'(buf_rd_addr), 32'd4);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("rr_ign_addr", 32'(buf_rd_addr), 32'd5);
      chk("rr_ign_busy", 32'(busy), 32'd1);
      chk("rr_ign_ifm_v", 32'(eng_ifm_valid), 32'd1);

      // start together with abort
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", 32'(busy), 32'd0);
      chk("sa_rd_en", 32'(buf_rd_en), 32'd0);
      chk("sa_addr", 32'(buf_rd_addr), 32'd0);
      @(posedge clk); #1;
      chk("sa_stay_busy", 32'(busy), 32'd0);
      chk("sa_stay_rd", 32'(buf_rd_en), 32'd0);
      chk("rr_order", 32'(bad_n - s_bad), 32'd0);

      // rst in WAIT_RES after 2 of 4 results
      mdl_en = 1'b0;
      pulse_start();
      t = 0;
      while (!eng_tile_go && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("rs_go", 32'(eng_tile_go), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      man_vld = 1'b1;
      man_dat = 16'hABCD;
      @(negedge clk);
      man_dat = 16'h1357;
      chk("rs_dv1", 32'(dout_valid), 32'd1);
      chk("rs_val1", ofmap_out, 32'h0000ABCD);
      @(negedge clk);
      man_vld = 1'b0;
      chk("rs_dv2", 32'(dout_valid), 32'd1);
      chk("rs_val2", ofmap_out, 32'h00001357);
      chk("rs_busy", 32'(busy), 32'd1);
      chk("rs_err", 32'(res_err), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_outs("rs");
      chk("rs_res_err", 32'(res_err), 32'd0);
      s_dout = dout_n;
      @(negedge clk);
      man_vld = 1'b1;
      man_dat = 16'h7777;
      @(negedge clk);
      man_vld = 1'b0;
      chk("late_dv", 32'(dout_valid), 32'd0);
      chk("late_ofmap", ofmap_out, 32'd0);
      chk("late_err", 32'(res_err), 32'd1);
      chk("late_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("late_dout_n", 32'(dout_n - s_dout), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
